stream_parity_unit: RTL and testbench

- Streaming parity generator/checker; next generation of the team's 8-bit combinational parity generator.
- Accumulates parity over multi-beat frames of DATA_W-bit words, with selectable even/odd sense.
- Generate mode: emits the frame parity. Check mode: compares against a received parity bit and flags mismatches.
- Sits between a valid/ready source and sink on link/storage datapaths; keeps a saturating error count.

---
 rtl/stream_parity_unit.sv | 133 +++++++++++++
 tb/tb_stream_parity_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_parity_unit.sv
// Streaming frame parity generator/checker with saturating error counter.
// Optional sticky error interrupt (err_irq/irq_clr) under `STREAM_PARITY_IRQ_EN.
module stream_parity_unit #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              odd_mode,
  input  logic              check_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic              out_error,
`ifdef STREAM_PARITY_IRQ_EN
  output logic              err_irq,
  input  logic              irq_clr,
`endif
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic             odd_q, odd_d;
  logic             chk_q, chk_d;
  logic             ov_q, ov_d;
  logic             op_q, op_d;
  logic             oe_q, oe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fire;
  logic eff_odd;
  logic eff_chk;
  logic result;
  logic frame_err;

  assign in_ready = !ov_q || out_ready;
  assign fire     = in_valid && in_ready;

  // First beat of a frame uses the live mode inputs; later beats use the latched copy.
  assign eff_odd   = (state_q == IDLE) ? odd_mode   : odd_q;
  assign eff_chk   = (state_q == IDLE) ? check_mode : chk_q;
  assign result    = acc_q ^ (^in_data) ^ eff_odd;
  assign frame_err = fire && in_last && eff_chk && (result != in_par);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    odd_d   = odd_q;
    chk_d   = chk_q;
    ov_d    = ov_q;
    op_d    = op_q;
    oe_d    = oe_q;
    cnt_d   = cnt_q;

    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end

    if (fire) begin
      if (state_q == IDLE) begin
        odd_d = odd_mode;
        chk_d = check_mode;
      end
      if (in_last) begin
        state_d = IDLE;
        acc_d   = 1'b0;
        ov_d    = 1'b1;
        op_d    = result;
        oe_d    = frame_err;
        if (frame_err && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = ACCUM;
        acc_d   = acc_q ^ (^in_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      odd_q   <= 1'b0;
      chk_q   <= 1'b0;
      ov_q    <= 1'b0;
      op_q    <= 1'b0;
      oe_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      odd_q   <= odd_d;
      chk_q   <= chk_d;
      ov_q    <= ov_d;
      op_q    <= op_d;
      oe_q    <= oe_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_parity = op_q;
  assign out_error  = oe_q;
  assign err_count  = cnt_q;

`ifdef STREAM_PARITY_IRQ_EN
  logic irq_q, irq_d;

  // Set takes priority over a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (frame_err) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign err_irq = irq_q;
`endif

endmodule

// File: tb/tb_stream_parity_unit.sv
// Directed bench for stream_parity_unit: frame-level parity model plus literal checks.
module tb_stream_parity_unit;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_par = 1'b0;
  logic              odd_mode = 1'b0;
  logic              check_mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_parity;
  logic              out_error;
  logic [CNT_W-1:0]  err_count;
`ifdef STREAM_PARITY_IRQ_EN
  logic              err_irq;
  logic              irq_clr = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  stream_parity_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_par     (in_par),
    .odd_mode   (odd_mode),
    .check_mode (check_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_error  (out_error),
`ifdef STREAM_PARITY_IRQ_EN
    .err_irq    (err_irq),
    .irq_clr    (irq_clr),
`endif
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: count ones across the whole frame, derive parity at the end.
  int m_ones = 0;
  bit m_open = 0, m_odd = 0, m_chk = 0;
  bit m_valid = 0, m_par = 0, m_err = 0, m_irq = 0;
  int m_cnt = 0;
  bit m_rdy, m_fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ones = 0; m_open = 0; m_valid = 0; m_par = 0; m_err = 0; m_cnt = 0; m_irq = 0;
    end else begin
      m_rdy  = !m_valid || out_ready;
      m_fire = in_valid && m_rdy;
`ifdef STREAM_PARITY_IRQ_EN
      if (irq_clr) m_irq = 0;
`endif
      if (m_valid && out_ready) m_valid = 0;
      if (m_fire) begin
        if (!m_open) begin
          m_odd  = odd_mode;
          m_chk  = check_mode;
          m_ones = 0;
        end
        m_ones += $countones(in_data);
        if (in_last) begin
          m_par   = ((m_ones % 2) == 1) ^ m_odd;
          m_err   = m_chk && (m_par != in_par);
          m_valid = 1;
          m_open  = 0;
          if (m_err) begin
            m_irq = 1;
            if (m_cnt < CMAX) m_cnt++;
          end
        end else begin
          m_open = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("err_count", 32'(err_count), 32'(m_cnt));
      if (m_valid) begin
        check("out_parity", 32'(out_parity), 32'(m_par));
        check("out_error", 32'(out_error), 32'(m_err));
      end
`ifdef STREAM_PARITY_IRQ_EN
      check("err_irq", 32'(err_irq), 32'(m_irq));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic last, input logic par,
                      input logic odd, input logic chk);
    in_data = d; in_last = last; in_par = par; odd_mode = odd; check_mode = chk;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL accept_timeout: got no in_ready expected acceptance within 20 cycles");
    in_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic par, input logic err, input int cnt);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_parity"}, 32'(out_parity), 32'(par));
    check({name, "_error"}, 32'(out_error), 32'(err));
    check({name, "_count"}, 32'(err_count), 32'(cnt));
  endtask

  initial begin
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step(1);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_parity", 32'(out_parity), 32'd0);

    // Generate, even, single beat.
    send(8'h07, 1, 0, 0, 0);
    lit("gen_even_07", 1'b1, 1'b0, 0);
    step(1);

    // Generate, odd then even, 3-beat frame with 11 ones; idle gaps mid-frame.
    send(8'h01, 0, 0, 1, 0); send(8'h03, 0, 0, 1, 0); send(8'hFF, 1, 0, 1, 0);
    lit("gen_odd_3b", 1'b0, 1'b0, 0);
    send(8'h01, 0, 0, 0, 0); step(2); send(8'h03, 0, 0, 0, 0); step(1);
    send(8'hFF, 1, 0, 0, 0);
    lit("gen_even_3b", 1'b1, 1'b0, 0);
    // Mode inputs toggled after the first beat are ignored.
    send(8'h01, 0, 0, 1, 0); send(8'h03, 0, 0, 0, 1); send(8'hFF, 1, 1, 0, 1);
    lit("gen_toggle", 1'b0, 1'b0, 0);
    step(1);

    // Check mode.
    send(8'hAA, 1, 1, 0, 1);
    lit("chk_aa", 1'b0, 1'b1, 1);
    send(8'h55, 1, 0, 0, 1);
    lit("chk_55", 1'b0, 1'b0, 1);
    send(8'h10, 0, 1, 1, 1); send(8'h00, 1, 1, 0, 0);
    lit("chk_odd_2b", 1'b0, 1'b1, 2);
    step(1);

    // Backpressure: result held, in_ready low; then consume and accept together.
    out_ready = 1'b0;
    send(8'h01, 1, 0, 0, 0);
    lit("bp_first", 1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_parity", 32'(out_parity), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h03, 1, 0, 0, 0);
    lit("bp_second", 1'b0, 1'b0, 2);
    step(2);

    // Saturation at 3 with CNT_W=2.
    for (int k = 0; k < 5; k++) begin
      send(8'hAA, 1, 1, 0, 1);
      lit("sat", 1'b0, 1'b1, (k + 3 > CMAX) ? CMAX : k + 3);
    end
    step(1);

    // Reset mid-frame discards partial frame.
    send(8'h01, 0, 0, 0, 0); send(8'h01, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_parity", 32'(out_parity), 32'd0);
    check("mid_rst_error", 32'(out_error), 32'd0);
    check("mid_rst_count", 32'(err_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    send(8'h01, 1, 0, 0, 0);
    lit("post_rst", 1'b1, 1'b0, 0);

`ifdef STREAM_PARITY_IRQ_EN
    send(8'hAA, 1, 1, 0, 1);
    check("irq_set", 32'(err_irq), 32'd1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("irq_clr", 32'(err_irq), 32'd0);
`endif

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
